// File: rtl/mem_arb4.sv
// Round-robin arbiter that shares one single-port 16-bit memory among four requesters.
// Each grant is a one-cycle issue, then for reads a fixed-latency wait and one return pulse.
module mem_arb4 #(
    parameter int LAT = 1,
    parameter int AW  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [AW-1:0] addr3,
    input  logic [15:0]   wdata0,
    input  logic [15:0]   wdata1,
    input  logic [15:0]   wdata2,
    input  logic [15:0]   wdata3,
    output logic [3:0]    gnt,
    output logic [3:0]    rvalid,
    output logic [15:0]   rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(LAT - 1);

    state_t        state, state_nx;
    logic [1:0]    ptr;
    logic [1:0]    owner;
    logic [2:0]    cnt;
    logic [1:0]    win;
    logic          found;
    logic [AW-1:0] sel_addr;
    logic [15:0]   sel_wdata;

    // Scan from ptr upward; the lowest offset that is requesting wins.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                win   = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (win)
            2'd0:    begin sel_addr = addr0; sel_wdata = wdata0; end
            2'd1:    begin sel_addr = addr1; sel_wdata = wdata1; end
            2'd2:    begin sel_addr = addr2; sel_wdata = wdata2; end
            default: begin sel_addr = addr3; sel_wdata = wdata3; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // mem_we is only high in ISSUE, so it doubles as the read/write flag there.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = ISSUE;
            ISSUE:   state_nx = mem_we ? IDLE : WAIT;
            WAIT:    if (cnt == 3'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 2'd0;
            owner     <= 2'd0;
            cnt       <= 3'd0;
            gnt       <= 4'd0;
            rvalid    <= 4'd0;
            rdata     <= 16'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 16'd0;
        end else begin
            gnt    <= 4'd0;
            rvalid <= 4'd0;
            mem_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= win;
                        ptr       <= win + 2'd1;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_we    <= we[win];
                        mem_en    <= 1'b1;
                        gnt       <= 4'b0001 << win;
                    end
                end
                ISSUE: begin
                    mem_we <= 1'b0;
                    if (!mem_we) cnt <= WAIT_INIT;
                end
                WAIT: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        rdata  <= mem_rdata;
                        rvalid <= 4'b0001 << owner;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb4.sv
// Randomized scoreboard bench for mem_arb4: a transaction-level arbiter/memory model
// predicts each grant and read return; a negedge monitor compares them to the DUT.
module tb_mem_arb4;

    localparam int LAT = 2;
    localparam int AW  = 15;
    localparam int M_DIR  = 0;
    localparam int M_FAIR = 1;
    localparam int M_RAND = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req, we;
    logic [AW-1:0] addr0, addr1, addr2, addr3;
    logic [15:0]   wdata0, wdata1, wdata2, wdata3;
    logic [3:0]    gnt, rvalid;
    logic [15:0]   rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;

    mem_arb4 #(.LAT(LAT), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Memory contents for never-written addresses.
    function automatic logic [15:0] init_val(input logic [AW-1:0] a);
        return {1'b0, a} ^ 16'hC3A5;
    endfunction

    // ---------------- memory responder (fixed read latency) ----------------
    logic [15:0] mem_store [int];
    logic [15:0] pipe [LAT];

    function automatic logic [15:0] mem_read(input logic [AW-1:0] a);
        return mem_store.exists(int'(a)) ? mem_store[int'(a)] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) mem_store[int'(mem_addr)] = mem_wdata;
        pipe[0] <= (mem_en && !mem_we) ? mem_read(mem_addr) : 16'($urandom);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[LAT-1];

    // ---------------- reference model ----------------
    typedef struct { int cyc; int idx; logic w; logic [AW-1:0] a; logic [15:0] d; } gexp_t;
    typedef struct { int cyc; int idx; logic [15:0] d; } rexp_t;
    typedef struct { int cyc; logic [AW-1:0] a; logic [15:0] d; } wexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    wexp_t wq[$];
    logic [15:0] ref_mem [int];
    int m_ptr = 0;
    int free_at = 0;
    logic [AW-1:0] last_addr = '0;
    logic [15:0]   last_wdata = 16'd0;
    logic [15:0]   last_rdata = 16'd0;

    function automatic logic [15:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    task automatic apply_writes();
        while (wq.size() > 0 && wq[0].cyc < cyc) begin
            ref_mem[int'(wq[0].a)] = wq[0].d;
            void'(wq.pop_front());
        end
    endtask

    // Requester agents
    logic [3:0]    act = 4'd0, wr = 4'd0, rearm = 4'd0;
    logic [AW-1:0] ad [4];
    logic [15:0]   wd [4];
    int mode = M_DIR;

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 15'h7FE0 + 15'($urandom_range(0, 31));
        return 15'($urandom_range(0, 31));
    endfunction

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [15:0] d);
        act[i] = 1'b1; wr[i] = w; ad[i] = a; wd[i] = d;
    endtask

    task automatic drive();
        req = act; we = wr;
        addr0 = ad[0]; addr1 = ad[1]; addr2 = ad[2]; addr3 = ad[3];
        wdata0 = wd[0]; wdata1 = wd[1]; wdata2 = wd[2]; wdata3 = wd[3];
    endtask

    // Arbitration decided at the end of this cycle if the port is free.
    task automatic model_cycle();
        int w;
        apply_writes();
        if (!rst && cyc >= free_at && req != 4'd0) begin
            w = 0;
            for (int k = 0; k < 4; k++) begin
                if (req[(m_ptr + k) % 4]) begin w = (m_ptr + k) % 4; break; end
            end
            gq.push_back('{cyc + 1, w, wr[w], ad[w], wd[w]});
            m_ptr = (w + 1) % 4;
            if (wr[w]) begin
                wq.push_back('{cyc + 1, ad[w], wd[w]});
                free_at = cyc + 2;
            end else begin
                rq.push_back('{cyc + 2 + LAT, w, ref_read(ad[w])});
                free_at = cyc + 2 + LAT;
            end
        end
    endtask

    task automatic assert_reset();
        apply_writes();
        rst = 1'b1;
        gq.delete(); rq.delete(); wq.delete();
        m_ptr = 0;
        last_addr = '0; last_wdata = 16'd0; last_rdata = 16'd0;
    endtask

    task automatic release_reset();
        rst = 1'b0;
        free_at = cyc;
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            if (gnt[i]) begin
                act[i] = 1'b0;
                rearm[i] = (mode == M_FAIR);
            end else if (rearm[i]) begin
                rearm[i] = 1'b0;
                set_req(i, 1'b1, rand_addr(), 16'($urandom));
            end else if (mode == M_RAND) begin
                if (act[i]) begin
                    if ($urandom_range(0, 19) == 0) act[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
                end
            end
        end
    endtask

    task automatic end_cycle();
        drive();
        model_cycle();
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},    32'(gnt), 32'd0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, "_rdata"},  32'(rdata), 32'd0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_maddr"},  32'(mem_addr), 32'd0);
        chk({tag, "_mwdata"}, 32'(mem_wdata), 32'd0);
    endtask

    // ---------------- monitor ----------------
    bit mon_on = 0;
    always @(negedge clk) begin
        if (mon_on) begin
            logic [3:0] eg, er;
            logic       ew, een;
            eg = 4'd0; er = 4'd0; ew = 1'b0; een = 1'b0;
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                eg = 4'b0001 << gq[0].idx;
                een = 1'b1;
                ew = gq[0].w;
                last_addr = gq[0].a;
                last_wdata = gq[0].d;
                void'(gq.pop_front());
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                er = 4'b0001 << rq[0].idx;
                last_rdata = rq[0].d;
                void'(rq.pop_front());
            end
            chk("mon_gnt", 32'(gnt), 32'(eg));
            chk("mon_mem_en", 32'(mem_en), 32'(een));
            chk("mon_mem_we", 32'(mem_we), 32'(ew));
            chk("mon_mem_addr", 32'(mem_addr), 32'(last_addr));
            chk("mon_mem_wdata", 32'(mem_wdata), 32'(last_wdata));
            chk("mon_rvalid", 32'(rvalid), 32'(er));
            chk("mon_rdata", 32'(rdata), 32'(last_rdata));
        end
    end

    // ---------------- stimulus ----------------
    int gidx [$];
    int gcyc [$];

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin ad[i] = '0; wd[i] = 16'd0; end
        drive();
        #1;
        assert_reset();
        #1;
        chk_all_zero("init");
        mon_on = 1;

        // Reset mid-cycle while a grant is live and all four are requesting.
        begin_cycle();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 15'(16 + i), 16'd0);
        release_reset();
        end_cycle();
        begin_cycle();
        chk("pre_rst_gnt", 32'(gnt), 32'h1);
        act = 4'b1111;
        assert_reset();
        #1;
        chk_all_zero("rst");
        end_cycle();
        step(1);
        begin_cycle();
        release_reset();
        end_cycle();
        begin_cycle();
        chk("first_gnt", 32'(gnt), 32'h1);
        end_cycle();
        step(25);

        // Single read through requester 2.
        begin_cycle(); assert_reset(); act = 4'd0; end_cycle();
        begin_cycle();
        release_reset();
        mem_store[int'(15'h1234)] = 16'hBEEF;
        ref_mem[int'(15'h1234)] = 16'hBEEF;
        set_req(2, 1'b0, 15'h1234, 16'd0);
        end_cycle();
        for (int n = 1; n <= 6; n++) begin
            begin_cycle();
            if (n == 1) begin
                chk("rd_gnt", 32'(gnt), 32'h4);
                chk("rd_mem_en", 32'(mem_en), 32'h1);
                chk("rd_mem_addr", 32'(mem_addr), 32'h1234);
            end else if (n == 4) begin
                chk("rd_rvalid", 32'(rvalid), 32'h4);
                chk("rd_rdata", 32'(rdata), 32'hBEEF);
            end else begin
                chk("rd_rvalid_quiet", 32'(rvalid), 32'h0);
            end
            end_cycle();
        end

        // Write through requester 0, then read it back through requester 3.
        begin_cycle();
        set_req(0, 1'b1, 15'h0010, 16'hAAAA);
        end_cycle();
        for (int n = 1; n <= 6; n++) begin
            begin_cycle();
            if (n == 1) begin
                chk("wr_gnt", 32'(gnt), 32'h1);
                chk("wr_mem_en", 32'(mem_en), 32'h1);
                chk("wr_mem_we", 32'(mem_we), 32'h1);
                chk("wr_mem_addr", 32'(mem_addr), 32'h0010);
                chk("wr_mem_wdata", 32'(mem_wdata), 32'hAAAA);
            end else if (n == 6) begin
                chk("wrrd_rvalid", 32'(rvalid), 32'h8);
                chk("wrrd_rdata", 32'(rdata), 32'hAAAA);
            end else begin
                chk("wr_no_rvalid", 32'(rvalid), 32'h0);
            end
            if (n == 2) set_req(3, 1'b0, 15'h0010, 16'd0);
            end_cycle();
        end

        // Abort: reset during WAIT of a read; no return may follow.
        begin_cycle(); assert_reset(); end_cycle();
        begin_cycle();
        release_reset();
        set_req(1, 1'b0, 15'h0055, 16'd0);
        end_cycle();
        for (int n = 1; n <= 8; n++) begin
            begin_cycle();
            if (n == 1) chk("ab_gnt", 32'(gnt), 32'h2);
            if (n == 2) begin
                act = 4'd0;
                assert_reset();
                #1;
                chk("ab_rvalid", 32'(rvalid), 32'h0);
            end
            if (n == 3) release_reset();
            if (n >= 3) chk_all_zero("ab_idle");
            end_cycle();
        end

        // Fairness: four writers, each re-requesting right after its grant.
        begin_cycle(); assert_reset(); end_cycle();
        begin_cycle();
        release_reset();
        mode = M_FAIR;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, rand_addr(), 16'($urandom));
        end_cycle();
        for (int n = 0; n < 20 && gidx.size() < 6; n++) begin
            begin_cycle();
            for (int i = 0; i < 4; i++) if (gnt[i]) begin gidx.push_back(i); gcyc.push_back(cyc); end
            end_cycle();
        end
        chk("fair_count", 32'(gidx.size()), 32'd6);
        for (int k = 0; k < gidx.size(); k++) begin
            chk("fair_order", 32'(gidx[k]), 32'(k % 4));
            if (k > 0) chk("fair_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd2);
        end
        begin_cycle(); mode = M_DIR; rearm = 4'd0; act = 4'd0; end_cycle();
        step(8);

        // Rotation: after a grant to 2, requesters 0 and 3 contend.
        begin_cycle(); assert_reset(); end_cycle();
        begin_cycle();
        release_reset();
        set_req(2, 1'b1, 15'h0002, 16'h2222);
        end_cycle();
        gidx.delete();
        for (int n = 0; n < 12 && gidx.size() < 3; n++) begin
            begin_cycle();
            for (int i = 0; i < 4; i++) if (gnt[i]) gidx.push_back(i);
            if (gnt[2]) begin
                set_req(0, 1'b1, 15'h0000, 16'h0A0A);
                set_req(3, 1'b1, 15'h0003, 16'h3B3B);
            end
            end_cycle();
        end
        chk("rot_count", 32'(gidx.size()), 32'd3);
        if (gidx.size() == 3) begin
            chk("rot_first", 32'(gidx[0]), 32'd2);
            chk("rot_second", 32'(gidx[1]), 32'd3);
            chk("rot_third", 32'(gidx[2]), 32'd0);
        end
        step(6);

        // Randomized traffic with one reset in the middle.
        mode = M_RAND;
        for (int n = 0; n < 3000; n++) begin
            begin_cycle();
            if (n == 1500) assert_reset();
            if (n == 1502) release_reset();
            end_cycle();
        end
        begin_cycle(); mode = M_DIR; act = 4'd0; end_cycle();
        step(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
